oam_dma_ctrl: RTL and testbench
===============================

Name: oam_dma_ctrl

Overview:
- Sequences NES sprite DMA and arbitrates the shared 64 KiB CPU memory bus between cpu_6502 and the DMA engine.
- A CPU write to the DMA trigger register starts the sequence: the block halts the CPU, takes the bus, and copies a 256-byte page into PPU OAM through the OAM data register. It then returns the bus to the CPU.
- The block sits between cpu_6502 and the memory/register decode (generic_ram plus PPU registers).

Parameters:
- TRIG_ADDR, 16'h4014, CPU write address that starts DMA; write data is the source page.
- OAM_DATA_ADDR, 16'h2004, destination address written once per byte.
- HALT_WAIT, 2, cycles the CPU keeps the bus after halt rises, so the CPU can finish its current access (≥1).
- XFER_LEN, 256, bytes per transfer (1..256).

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous active-low reset (0 = reset).
- cpu_addr  in  16  CPU bus address.
- cpu_wdata  in  8  CPU write data.
- cpu_we  in  1  CPU write enable.
- cpu_re  in  1  CPU read enable.
- mem_addr  out  16  arbitrated bus address.
- mem_wdata  out  8  arbitrated write data.
- mem_we  out  1  arbitrated write enable.
- mem_re  out  1  arbitrated read enable.
- mem_rdata  in  8  bus read data, valid the cycle after the address (synchronous RAM, latency 1).
- cpu_halt  out  1  to cpu_6502 halt input; 1 = CPU stalled.
- dma_busy  out  1  high from trigger acceptance until the transfer completes.

Behaviour:
- Reset (rst=0, async):
  - State goes to IDLE; page, index, wait counter and parity are cleared.
  - cpu_halt=0, dma_busy=0.
  - Bus is owned by the CPU.
- Reset mid-transfer: abort immediately; no further OAM writes occur.
- Bus mux:
  - In IDLE and WAIT, mem_* = cpu_* (combinational pass-through).
  - In RD and WR, mem_* are driven by the DMA engine and cpu_we/cpu_re are ignored.
- Parity: a 1-bit free-running register toggles every cycle; it is 0 in the first cycle after reset release.
- IDLE:
  - Trigger condition: cpu_we=1 and cpu_addr==TRIG_ADDR at a rising edge.
  - On trigger: latch page=cpu_wdata, index=0, wait count=HALT_WAIT, then go to WAIT.
  - The CPU's own trigger write still reaches the bus (transparent).
- WAIT:
  - cpu_halt=1, dma_busy=1, bus still owned by the CPU.
  - The counter decrements each cycle; at 0, go to RD.
  - If parity=1 in the cycle the counter would reach RD, insert one extra WAIT cycle. This aligns RD to even parity.
- RD:
  - mem_addr = {page, index[7:0]}, mem_re=1, mem_we=0.
  - Next state: WR.
- WR:
  - mem_addr=OAM_DATA_ADDR, mem_wdata=mem_rdata (combinational; carries data for the RD address), mem_we=1, mem_re=0.
  - If index==XFER_LEN-1, go to IDLE; otherwise increment index and go to RD.
- Timing:
  - Exactly XFER_LEN RD/WR pairs (2·XFER_LEN bus cycles).
  - Source address never leaves the page; the index is internal, at most XFER_LEN-1, no carry into the page.
  - cpu_halt and dma_busy fall in the first cycle after the final WR.
  - Halt duration is HALT_WAIT + parity pad (0/1) + 2·XFER_LEN cycles.
- Trigger writes during WAIT/RD/WR are ignored (no restart, no page change).
- A new trigger in the first IDLE cycle after completion is accepted normally.
- Page 0xFF is valid: source range FF00–FFFF.

Test Plan:
- After reset, CPU writes 0x03 to 4014 on an even-parity setup, HALT_WAIT=2, RAM 0300–03FF = i^0x5A → cpu_halt high for 514 cycles; 256 writes to 2004 with data 0x5A,0x5B,…,0xA5 in order; dma_busy falls with cpu_halt.
- Same trigger one cycle later (odd parity) → exactly one extra WAIT cycle; halt lasts 515 cycles; data identical.
- During WAIT, CPU asserts cpu_re at 0x0010 → bus shows the CPU access; the first DMA read at 0x0300 appears only after the wait.
- Second write of 0x07 to 4014 injected mid-transfer (force cpu_we) → ignored; all source addresses remain 03xx; count stays 256.
- rst pulsed low at transfer byte 100 → cpu_halt=0 and mem_we=0 asynchronously; no 2004 writes after release; the next trigger with page 0xFF reads FF00–FFFF.
- XFER_LEN=4, page 0x02 → RD addresses 0200..0203 alternating with WR to 2004; halt 8+HALT_WAIT(+pad) cycles; back-to-back re-trigger in the first IDLE cycle accepted.

Source files
------------

// File: rtl/oam_dma_ctrl_if.sv
// rtl/oam_dma_ctrl_if.sv - CPU-side and arbitrated memory-side bus of the sprite DMA controller
interface oam_dma_ctrl_if;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_we;
    logic        cpu_re;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [7:0]  mem_rdata;
    logic        cpu_halt;
    logic        dma_busy;

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_we, cpu_re, mem_rdata,
        output mem_addr, mem_wdata, mem_we, mem_re, cpu_halt, dma_busy
    );

    modport master (
        output cpu_addr, cpu_wdata, cpu_we, cpu_re, mem_rdata,
        input  mem_addr, mem_wdata, mem_we, mem_re, cpu_halt, dma_busy
    );
endinterface

// File: rtl/oam_dma_ctrl.sv
// rtl/oam_dma_ctrl.sv - NES sprite DMA sequencer and CPU/DMA memory bus arbiter
module oam_dma_ctrl #(
    parameter logic [15:0] TRIG_ADDR     = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
    parameter int unsigned HALT_WAIT     = 2,
    parameter int unsigned XFER_LEN      = 256
) (
    input logic           clk,
    input logic           rst,
    oam_dma_ctrl_if.slave bus
);
    localparam int unsigned       WCNT_W    = $clog2(HALT_WAIT + 1);
    localparam logic [WCNT_W-1:0] WAIT_INIT = WCNT_W'(HALT_WAIT);
    localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);
    localparam logic [7:0]        LAST_IDX  = 8'(XFER_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RD,
        ST_WR
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        page_q, page_d;
    logic [7:0]        idx_q, idx_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              par_q;
    logic              trig;

    assign trig = bus.cpu_we && (bus.cpu_addr == TRIG_ADDR);

    always_ff @(posedge clk or negedge rst) begin : state_reg
        if (!rst) begin
            state_q <= ST_IDLE;
            page_q  <= 8'h00;
            idx_q   <= 8'h00;
            wcnt_q  <= '0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            idx_q   <= idx_d;
            wcnt_q  <= wcnt_d;
            par_q   <= ~par_q;
        end
    end

    // The last regular WAIT cycle holds one extra cycle when it falls on odd
    // parity, so every transfer starts at the same phase of the parity clock.
    always_comb begin : next_state
        state_d = state_q;
        page_d  = page_q;
        idx_d   = idx_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (trig) begin
                    state_d = ST_WAIT;
                    page_d  = bus.cpu_wdata;
                    idx_d   = 8'h00;
                    wcnt_d  = WAIT_INIT;
                end
            end
            ST_WAIT: begin
                if (wcnt_q != '0) begin
                    wcnt_d = wcnt_q - WCNT_ONE;
                end
                if ((wcnt_q == '0) || ((wcnt_q == WCNT_ONE) && !par_q)) begin
                    state_d = ST_RD;
                end
            end
            ST_RD: begin
                state_d = ST_WR;
            end
            ST_WR: begin
                if (idx_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = ST_RD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin : outputs
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_wdata = bus.cpu_wdata;
        bus.mem_we    = bus.cpu_we;
        bus.mem_re    = bus.cpu_re;
        bus.cpu_halt  = 1'b0;
        bus.dma_busy  = 1'b0;
        case (state_q)
            ST_WAIT: begin
                bus.cpu_halt = 1'b1;
                bus.dma_busy = 1'b1;
            end
            ST_RD: begin
                bus.mem_addr  = {page_q, idx_q};
                bus.mem_wdata = 8'h00;
                bus.mem_we    = 1'b0;
                bus.mem_re    = 1'b1;
                bus.cpu_halt  = 1'b1;
                bus.dma_busy  = 1'b1;
            end
            // Read data from the preceding RD cycle is forwarded straight to OAM.
            ST_WR: begin
                bus.mem_addr  = OAM_DATA_ADDR;
                bus.mem_wdata = bus.mem_rdata;
                bus.mem_we    = 1'b1;
                bus.mem_re    = 1'b0;
                bus.cpu_halt  = 1'b1;
                bus.dma_busy  = 1'b1;
            end
            default: begin
            end
        endcase
    end
endmodule

// File: tb/tb_oam_dma_ctrl.sv
// tb/tb_oam_dma_ctrl.sv - randomized self-checking bench for oam_dma_ctrl against a cycle-count reference model
module tb_oam_dma_ctrl;
    localparam logic [15:0] OAM    = 16'h2004;
    localparam logic [15:0] TRIG_A = 16'h4014;
    localparam logic [15:0] TRIG_B = 16'h4016;
    localparam int          HW_A   = 2;
    localparam int          HW_B   = 3;
    localparam int          LEN_A  = 256;
    localparam int          LEN_B  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_wdata = 8'h00;
    logic        cpu_we = 1'b0;
    logic        cpu_re = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc;

    logic [7:0]  ram [0:65535];
    logic [7:0]  rdata_q [2];
    logic [15:0] addr_w [2];
    logic [7:0]  wdata_w [2];
    logic        we_w [2];
    logic        re_w [2];
    logic        halt_w [2];
    logic        busy_w [2];

    int          halt_n [2];
    int          wr_n [2];
    int          rd_n [2];
    int          busy_bad [2];
    int          stray_n [2];
    logic [7:0]  wr_log [2][1024];
    logic [15:0] rd_log [2][1024];
    int          rd_cyc [2][1024];

    int t0, h0, w0, r0, b0;

    oam_dma_ctrl_if bus_a ();
    oam_dma_ctrl_if bus_b ();

    assign bus_a.cpu_addr  = cpu_addr;
    assign bus_a.cpu_wdata = cpu_wdata;
    assign bus_a.cpu_we    = cpu_we;
    assign bus_a.cpu_re    = cpu_re;
    assign bus_a.mem_rdata = rdata_q[0];
    assign bus_b.cpu_addr  = cpu_addr;
    assign bus_b.cpu_wdata = cpu_wdata;
    assign bus_b.cpu_we    = cpu_we;
    assign bus_b.cpu_re    = cpu_re;
    assign bus_b.mem_rdata = rdata_q[1];

    assign addr_w[0]  = bus_a.mem_addr;
    assign wdata_w[0] = bus_a.mem_wdata;
    assign we_w[0]    = bus_a.mem_we;
    assign re_w[0]    = bus_a.mem_re;
    assign halt_w[0]  = bus_a.cpu_halt;
    assign busy_w[0]  = bus_a.dma_busy;
    assign addr_w[1]  = bus_b.mem_addr;
    assign wdata_w[1] = bus_b.mem_wdata;
    assign we_w[1]    = bus_b.mem_we;
    assign re_w[1]    = bus_b.mem_re;
    assign halt_w[1]  = bus_b.cpu_halt;
    assign busy_w[1]  = bus_b.dma_busy;

    oam_dma_ctrl #(
        .TRIG_ADDR(TRIG_A), .OAM_DATA_ADDR(OAM), .HALT_WAIT(HW_A), .XFER_LEN(LEN_A)
    ) u_dut_a (
        .clk(clk), .rst(rst), .bus(bus_a)
    );

    oam_dma_ctrl #(
        .TRIG_ADDR(TRIG_B), .OAM_DATA_ADDR(OAM), .HALT_WAIT(HW_B), .XFER_LEN(LEN_B)
    ) u_dut_b (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (re_w[d]) rdata_q[d] <= ram[addr_w[d]];
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                if (halt_w[d]) halt_n[d] <= halt_n[d] + 1;
                if (busy_w[d] !== halt_w[d]) busy_bad[d] <= busy_bad[d] + 1;
                if (we_w[d] && addr_w[d] == OAM) begin
                    if (halt_w[d]) begin
                        wr_log[d][wr_n[d] & 1023] <= wdata_w[d];
                        wr_n[d] <= wr_n[d] + 1;
                    end else begin
                        stray_n[d] <= stray_n[d] + 1;
                    end
                end
                if (re_w[d] && halt_w[d] && !cpu_re) begin
                    rd_log[d][rd_n[d] & 1023] <= addr_w[d];
                    rd_cyc[d][rd_n[d] & 1023] <= cyc;
                    rd_n[d] <= rd_n[d] + 1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_parity(input int p);
        @(negedge clk);
        while ((cyc & 1) != p) @(negedge clk);
    endtask

    // Called at a falling edge with DUT d idle; returns one cycle later.
    task automatic trigger(input int d, input logic [7:0] page);
        h0 = halt_n[d];
        w0 = wr_n[d];
        r0 = rd_n[d];
        b0 = busy_bad[d];
        cpu_addr  = (d == 0) ? TRIG_A : TRIG_B;
        cpu_wdata = page;
        cpu_we    = 1'b1;
        t0        = cyc;
        @(negedge clk);
        cpu_we    = 1'b0;
        cpu_addr  = 16'h0000;
        cpu_wdata = 8'($urandom);
    endtask

    // Returns in the first IDLE cycle after the transfer.
    task automatic finish_check(input int d, input logic [7:0] page, input string nm);
        int len, hw, pad, budget, errs_d, errs_a, first_rd;
        len    = (d == 0) ? LEN_A : LEN_B;
        hw     = (d == 0) ? HW_A : HW_B;
        pad    = (t0 + hw) & 1;
        budget = 0;
        while (halt_w[d] !== 1'b0 && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        chk({nm, ".done"}, budget < 2000, 1);
        chk({nm, ".halt_cycles"}, halt_n[d] - h0, hw + pad + 2 * len);
        chk({nm, ".oam_writes"}, wr_n[d] - w0, len);
        chk({nm, ".dma_reads"}, rd_n[d] - r0, len);
        errs_d = 0;
        errs_a = 0;
        for (int k = 0; k < len; k++) begin
            if (wr_log[d][(w0 + k) & 1023] !== ram[{page, 8'(k)}]) errs_d++;
            if (rd_log[d][(r0 + k) & 1023] !== {page, 8'(k)}) errs_a++;
        end
        chk({nm, ".data_errs"}, errs_d, 0);
        chk({nm, ".addr_errs"}, errs_a, 0);
        first_rd = t0 + 1 + hw + pad;
        chk({nm, ".first_rd_cycle"}, rd_cyc[d][r0 & 1023], first_rd);
        chk({nm, ".last_rd_cycle"}, rd_cyc[d][(r0 + len - 1) & 1023], first_rd + 2 * (len - 1));
        chk({nm, ".busy_eq_halt"}, busy_bad[d] - b0, 0);
        chk({nm, ".stray_oam"}, stray_n[d], 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pg;
        int         budget;
        int         d;

        for (int a = 0; a < 65536; a++) ram[a] = 8'($urandom);
        for (int i = 0; i < 256; i++) ram[16'h0300 + i] = 8'(i) ^ 8'h5A;

        cpu_addr = 16'h1234;
        cpu_re   = 1'b1;
        #12;
        chk("reset.halt_a", halt_w[0], 0);
        chk("reset.busy_a", busy_w[0], 0);
        chk("reset.halt_b", halt_w[1], 0);
        chk("reset.pass_addr", addr_w[0], 16'h1234);
        chk("reset.pass_re", re_w[0], 1);
        cpu_re   = 1'b0;
        cpu_addr = 16'h0000;
        @(negedge clk);
        rst = 1'b1;

        wait_parity(0);
        trigger(0, 8'h03);
        finish_check(0, 8'h03, "even");

        wait_parity(1);
        trigger(0, 8'h03);
        finish_check(0, 8'h03, "odd");

        wait_cycles(3);
        pg = 8'($urandom);
        trigger(0, pg);
        #1;
        cpu_addr = 16'h0010;
        cpu_re   = 1'b1;
        #1;
        chk("wait.cpu_addr", addr_w[0], 16'h0010);
        chk("wait.cpu_re", re_w[0], 1);
        chk("wait.halted", halt_w[0], 1);
        @(negedge clk);
        #1;
        cpu_re   = 1'b0;
        cpu_addr = 16'h0000;
        finish_check(0, pg, "wait_cpu");

        wait_cycles(2);
        trigger(0, 8'h03);
        wait_cycles(40);
        cpu_addr  = TRIG_A;
        cpu_wdata = 8'h07;
        cpu_we    = 1'b1;
        @(negedge clk);
        cpu_we    = 1'b0;
        cpu_addr  = 16'h0000;
        finish_check(0, 8'h03, "inject");

        wait_cycles(2);
        trigger(0, 8'($urandom));
        budget = 0;
        while ((wr_n[0] - w0) < 100 && budget < 1000) begin
            @(negedge clk);
            budget++;
        end
        chk("rst.reached_byte100", budget < 1000, 1);
        #2 rst = 1'b0;
        #1;
        chk("rst.halt_async", halt_w[0], 0);
        chk("rst.busy_async", busy_w[0], 0);
        chk("rst.mem_we_async", we_w[0], 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        w0 = wr_n[0];
        wait_cycles(30);
        chk("rst.no_oam_after", wr_n[0] - w0, 0);
        chk("rst.idle_after", halt_w[0], 0);
        trigger(0, 8'hFF);
        finish_check(0, 8'hFF, "page_ff");

        wait_cycles(2);
        trigger(1, 8'h02);
        finish_check(1, 8'h02, "len4");
        pg = 8'($urandom);
        trigger(1, pg);
        finish_check(1, pg, "len4_b2b");

        for (int it = 0; it < 6; it++) begin
            d  = $urandom_range(0, 1);
            pg = 8'($urandom);
            for (int k = 0; k < 256; k++) ram[{pg, 8'(k)}] = 8'($urandom);
            wait_cycles($urandom_range(0, 5));
            trigger(d, pg);
            finish_check(d, pg, $sformatf("rand%0d", it));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
